dut_seven_segment_1: RTL and testbench



---
 rtl/seg7_pkg.sv | 22 ++
 rtl/seg7_decoder.sv | 15 +
 rtl/dut_seven_segment_1.sv | 65 ++++++
 tb/tb_dut_seven_segment_1.sv | 133 +++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions.
//   SEG7_FONT    : 16-entry glyph table, 8 bits {dp,g,f,e,d,c,b,a}, dp always 0
//   SEG7_DP_BIT  : bit position of the decimal point in the output byte
//   seg7_encode  : 4-bit value -> 7-bit {g..a} pattern, bit = 1 means segment lit
package seg7_pkg;

  localparam int SEG7_DP_BIT = 7;

  localparam logic [7:0] SEG7_FONT [0:15] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F,   // 0 1 2 3
    8'h66, 8'h6D, 8'h7D, 8'h07,   // 4 5 6 7
    8'h7F, 8'h6F, 8'h77, 8'h7C,   // 8 9 A b
    8'h39, 8'h5E, 8'h79, 8'h71    // C d E F
  };

  function automatic logic [6:0] seg7_encode(input logic [3:0] d);
    logic [7:0] entry;
    entry = SEG7_FONT[d];
    return entry[6:0];
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex-to-seven-segment decoder.
//   digit : in  4  value 0..15
//   glyph : out 7  {g,f,e,d,c,b,a}, bit = 1 means segment lit (active-high)
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = seg7_encode(digit);
  end

endmodule

// File: rtl/dut_seven_segment_1.sv
// Free-running single-digit counter driving a 7-segment display with decimal point.
// The digit advances once every TICKS_PER_STEP clocks, counting 0..MAX_DIGIT and
// wrapping to 0. The decimal point lights while the digit sits at MAX_DIGIT.
//   clk : in  1  system clock
//   rst : in  1  synchronous active-high reset
//   seg : out 8  registered {dp,g,f,e,d,c,b,a}; inverted when ACTIVE_LOW = 1
module dut_seven_segment_1
  import seg7_pkg::*;
#(
  parameter int TICKS_PER_STEP = 1,
  parameter int MAX_DIGIT      = 9,
  parameter bit ACTIVE_LOW     = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] seg
);

  localparam int TICK_W = $clog2(TICKS_PER_STEP + 1);
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICKS_PER_STEP - 1);
  localparam logic [3:0]        DIGIT_LAST = 4'(MAX_DIGIT);
  localparam logic [7:0]        POLARITY   = ACTIVE_LOW ? 8'hFF : 8'h00;
  // Reset shows digit 0; MAX_DIGIT >= 1 so the dp is never set here.
  localparam logic [7:0]        SEG_RESET  = {1'b0, seg7_encode(4'd0)} ^ POLARITY;

  logic [TICK_W-1:0] tick;
  logic [TICK_W-1:0] tick_next;
  logic [3:0]        digit;
  logic [3:0]        digit_next;
  logic              step;
  logic [6:0]        glyph;
  logic [7:0]        seg_next;

  always_comb begin
    step       = (tick == TICK_LAST);
    tick_next  = step ? '0 : tick + TICK_W'(1);
    digit_next = digit;
    if (step) begin
      digit_next = (digit == DIGIT_LAST) ? 4'd0 : digit + 4'd1;
    end
  end

  // Decode the upcoming digit so seg updates on the same edge as the digit itself.
  seg7_decoder u_decoder (
    .digit (digit_next),
    .glyph (glyph)
  );

  always_comb begin
    seg_next = {(digit_next == DIGIT_LAST), glyph} ^ POLARITY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick  <= '0;
      digit <= 4'd0;
      seg   <= SEG_RESET;
    end else begin
      tick  <= tick_next;
      digit <= digit_next;
      seg   <= seg_next;
    end
  end

endmodule

// File: tb/tb_dut_seven_segment_1.sv
module tb_dut_seven_segment_1;

  logic       clk;
  logic       rst;
  logic [7:0] seg_def;   // TICKS_PER_STEP=1, MAX_DIGIT=9,  ACTIVE_LOW=0
  logic [7:0] seg_slow;  // TICKS_PER_STEP=3, MAX_DIGIT=9,  ACTIVE_LOW=0
  logic [7:0] seg_hex;   // TICKS_PER_STEP=1, MAX_DIGIT=15, ACTIVE_LOW=1

  int errors = 0;
  int checks = 0;

  dut_seven_segment_1 u_def (.clk(clk), .rst(rst), .seg(seg_def));
  dut_seven_segment_1 #(.TICKS_PER_STEP(3)) u_slow (.clk(clk), .rst(rst), .seg(seg_slow));
  dut_seven_segment_1 #(.TICKS_PER_STEP(1), .MAX_DIGIT(15), .ACTIVE_LOW(1'b1))
    u_hex (.clk(clk), .rst(rst), .seg(seg_hex));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the displayed value is simply how many whole steps have elapsed
  // since reset was last released, modulo the digit range.
  logic [7:0] font [0:15] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                              8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  function automatic logic [7:0] model_seg(input int edges, input int tps, input int maxd,
                                           input bit al);
    int d;
    logic [7:0] p;
    d = (edges / tps) % (maxd + 1);
    p = font[d];
    if (d == maxd) p = p | 8'h80;
    if (al) p = ~p;
    return p;
  endfunction

  int  edges = 0;       // non-reset edges since the last reset edge
  bit  armed = 1'b0;    // a reset edge has been seen, outputs are defined

  always @(posedge clk) begin
    if (rst) begin
      edges <= 0;
      armed <= 1'b1;
    end else begin
      edges <= edges + 1;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Continuous comparison of all three instances against the model.
  always @(negedge clk) begin
    if (armed) begin
      check("model_def",  seg_def,  model_seg(edges, 1, 9, 1'b0));
      check("model_slow", seg_slow, model_seg(edges, 3, 9, 1'b0));
      check("model_hex",  seg_hex,  model_seg(edges, 1, 15, 1'b1));
    end
  end

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] seq_def  [0:9]  = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D,
                                  8'h7D, 8'h07, 8'h7F, 8'hEF, 8'h3F};
  logic [7:0] seq_slow [0:9]  = '{8'h3F, 8'h3F, 8'h06, 8'h06, 8'h06,
                                  8'h5B, 8'h5B, 8'h5B, 8'h4F, 8'h4F};

  initial begin
    rst = 1'b1;
    // Reset for two edges, then held for twenty.
    repeat (2) edge_sample();
    check("reset_def", seg_def, 8'h3F);
    check("reset_hex", seg_hex, 8'hC0);
    repeat (20) edge_sample();
    check("reset_hold_def",  seg_def,  8'h3F);
    check("reset_hold_slow", seg_slow, 8'h3F);

    // Release and walk through one full decade.
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      edge_sample();
      check($sformatf("seq_def[%0d]", i), seg_def, seq_def[i]);
      check($sformatf("seq_slow[%0d]", i), seg_slow, seq_slow[i]);
    end

    // Free run; the model process covers the repeating pattern.
    repeat (25) edge_sample();

    // Reset mid-count at digit 5.
    @(negedge clk) rst = 1'b1;
    edge_sample();
    @(negedge clk) rst = 1'b0;
    repeat (5) edge_sample();
    check("mid_digit5", seg_def, 8'h6D);
    @(negedge clk) rst = 1'b1;
    edge_sample();
    check("mid_reset", seg_def, 8'h3F);
    repeat (19) edge_sample();
    check("mid_reset_hold", seg_def, 8'h3F);
    @(negedge clk) rst = 1'b0;
    edge_sample();
    check("mid_release", seg_def, 8'h06);

    // Hex/active-low instance: reach digit 15, then wrap.
    @(negedge clk) rst = 1'b1;
    edge_sample();
    @(negedge clk) rst = 1'b0;
    repeat (15) edge_sample();
    check("hex_digit15", seg_hex, 8'h0E);
    edge_sample();
    check("hex_wrap", seg_hex, 8'hC0);

    // Randomised reset pulses over a long run.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk) rst = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
